// File: rtl/gate_min_sync.sv
// Registered evaluator for z = (a & b) | (~a & c), exposing both product terms,
// plus sticky coverage of which {a,b,c} combinations have been sampled.
module gate_min_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic       w1,
  output logic       w2,
  output logic       z,
  output logic       out_valid,
  output logic [7:0] seen,
  output logic       all_seen
);

  localparam int STAGES = 1;

  typedef struct packed {
    logic w1;
    logic w2;
    logic z;
  } term_t;

  term_t             term_d, term_q;
  logic [7:0]        seen_d, seen_q;
  logic              all_seen_q;
  logic [STAGES:0]   vld_pipe;
  logic [2:0]        idx;

  assign vld_pipe[0] = in_valid;
  assign idx         = {a, b, c};

  // Inputs are only looked at under in_valid, so X on a/b/c while idle
  // never reaches any register.
  always_comb begin
    term_d = term_q;
    seen_d = seen_q;
    if (in_valid) begin
      term_d.w1   = a & b;
      term_d.w2   = ~a & c;
      term_d.z    = (a & b) | (~a & c);
      seen_d[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      term_q               <= '0;
      seen_q               <= '0;
      all_seen_q           <= 1'b0;
      vld_pipe[STAGES:1]   <= '0;
    end else begin
      term_q               <= term_d;
      seen_q               <= seen_d;
      all_seen_q           <= &seen_d;
      vld_pipe[STAGES:1]   <= vld_pipe[STAGES-1:0];
    end
  end

  assign w1        = term_q.w1;
  assign w2        = term_q.w2;
  assign z         = term_q.z;
  assign out_valid = vld_pipe[STAGES];
  assign seen      = seen_q;
  assign all_seen  = all_seen_q;

endmodule

// File: tb/tb_gate_min_sync.sv
// Directed bench for gate_min_sync: reset, sweep, hold, partial coverage,
// reset priority and mid-sweep reset, against hand-computed tables.
module tb_gate_min_sync;

  logic       clk = 1'b0;
  logic       rst, in_valid, a, b, c;
  logic       w1, w2, z, out_valid, all_seen;
  logic [7:0] seen;

  int checks   = 0;
  int failures = 0;

  // Truth tables indexed by {a,b,c}: z minterms 1,3,6,7; w1 = 6,7; w2 = 1,3.
  logic [7:0] z_tab  = 8'hCA;
  logic [7:0] w1_tab = 8'hC0;
  logic [7:0] w2_tab = 8'h0A;

  gate_min_sync dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .w1(w1), .w2(w2), .z(z), .out_valid(out_valid),
    .seen(seen), .all_seen(all_seen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [2:0] abc);
    @(negedge clk);
    rst = r; in_valid = v; {a, b, c} = abc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ew1, input logic ew2, input logic ez,
                         input logic eov, input logic [7:0] eseen, input logic eall);
    chk({tag, ".w1"},        {7'd0, w1},        {7'd0, ew1});
    chk({tag, ".w2"},        {7'd0, w2},        {7'd0, ew2});
    chk({tag, ".z"},         {7'd0, z},         {7'd0, ez});
    chk({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, eov});
    chk({tag, ".seen"},      seen,              eseen);
    chk({tag, ".all_seen"},  {7'd0, all_seen},  {7'd0, eall});
    chk({tag, ".excl"},      {7'd0, w1 & w2},   8'd0);
  endtask

  task automatic sweep(input string tag, input int n);
    logic [7:0] exp_seen;
    exp_seen = 8'h00;
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, 3'(i));
      exp_seen[i] = 1'b1;
      chk_all($sformatf("%s[%0d]", tag, i), w1_tab[i], w2_tab[i], z_tab[i],
              1'b1, exp_seen, i == 7);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;

    // Reset for two cycles
    drive(1'b1, 1'b0, 3'b000);
    drive(1'b1, 1'b0, 3'b000);
    chk_all("reset", 0, 0, 0, 0, 8'h00, 0);

    // Full sweep, then idle: out_valid drops, everything else holds
    sweep("sweep", 8);
    drive(1'b0, 1'b0, 3'b000);
    chk_all("sweep_idle", 1, 0, 1, 0, 8'hFF, 1);

    // Hold after sampling 110, including X inputs while idle
    drive(1'b0, 1'b1, 3'b110);
    chk_all("hold_cap", 1, 0, 1, 1, 8'hFF, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 3'b000);
      chk_all($sformatf("hold[%0d]", i), 1, 0, 1, 0, 8'hFF, 1);
    end
    drive(1'b1, 1'b0, 3'b000);
    drive(1'b0, 1'b1, 3'b110);
    drive(1'b0, 1'b0, 3'bxxx);
    chk_all("hold_x", 1, 0, 1, 0, 8'h40, 0);

    // Partial coverage: 011 twice, then 101
    drive(1'b1, 1'b0, 3'b000);
    drive(1'b0, 1'b1, 3'b011);
    chk_all("part0", 0, 1, 1, 1, 8'h08, 0);
    drive(1'b0, 1'b1, 3'b011);
    chk_all("part1", 0, 1, 1, 1, 8'h08, 0);
    drive(1'b0, 1'b1, 3'b101);
    chk_all("part2", 0, 0, 0, 1, 8'h28, 0);

    // Reset wins over a same-edge sample
    drive(1'b1, 1'b1, 3'b111);
    chk_all("rst_prio", 0, 0, 0, 0, 8'h00, 0);

    // Mid-sweep reset, then a full sweep from scratch
    sweep("mid", 4);
    drive(1'b1, 1'b0, 3'b000);
    chk_all("mid_rst", 0, 0, 0, 0, 8'h00, 0);
    sweep("resweep", 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
